// File: rtl/muldiv_iter_64.sv
// Iterative unsigned multiply (shift-add) / divide (restoring) unit, one result bit per cycle.
// Latency: XLEN+1 cycles from accepted start to o_done; 1 cycle for divide-by-zero.
// Backpressure: o_busy is high in RUN, and i_start is ignored there (no queuing).
//
// Ports:
//   i_clk, i_rst_n  clock (rising edge), async active-low reset
//   i_start         request, accepted in IDLE or DONE
//   i_op            00 MUL (low), 01 MULHU (high), 10 DIVU, 11 REMU
//   i_a, i_b        multiplicand/dividend, multiplier/divisor; sampled only at accept
//   o_busy          high while iterating
//   o_done          one-cycle pulse, o_result valid
//   o_result        registered result, held until the next operation completes
module muldiv_iter_64 #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 7    // 2**CNT_W must exceed XLEN
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_start,
  input  logic [1:0]      i_op,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  output logic            o_busy,
  output logic            o_done,
  output logic [XLEN-1:0] o_result
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  // Operation context captured at accept
  logic [1:0]        op_q;
  logic [XLEN-1:0]   opnd_q;   // multiplicand for MUL*, divisor for DIV*
  logic [CNT_W-1:0]  cnt_q;
  logic [XLEN-1:0]   result_q;

  // Multiply: low half starts as the multiplier and is consumed from the LSB
  // while the product grows in from the top.
  logic [2*XLEN-1:0] prod_q;

  // Divide: quo_q starts as the dividend; its MSBs are shifted into the
  // partial remainder while quotient bits are shifted in at the bottom.
  logic [XLEN:0]     rem_q;
  logic [XLEN-1:0]   quo_q;

  logic accept;
  logic div_zero;
  logic last_iter;

  assign accept    = i_start && (state != S_RUN);
  assign div_zero  = i_op[1] && (i_b == '0);
  assign last_iter = (state == S_RUN) && (cnt_q == CNT_W'(XLEN - 1));

  // ---------------------------------------------------------------------------
  // One iteration of each algorithm, computed every cycle; only the one
  // matching op_q is ever selected for the result.
  // ---------------------------------------------------------------------------
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] prod_step;
  logic [XLEN:0]     rem_shift;
  logic [XLEN+1:0]   rem_diff;
  logic              q_bit;
  logic [XLEN:0]     rem_step;
  logic [XLEN-1:0]   quo_step;
  logic [XLEN-1:0]   res_step;

  always_comb begin
    mul_sum   = {1'b0, prod_q[2*XLEN-1:XLEN]} +
                (prod_q[0] ? {1'b0, opnd_q} : {(XLEN+1){1'b0}});
    // The carry out of the add becomes the new top bit after the right shift
    prod_step = {mul_sum, prod_q[XLEN-1:1]};

    rem_shift = {rem_q[XLEN-1:0], quo_q[XLEN-1]};
    // One extra bit so the sign of the trial subtraction is visible
    rem_diff  = {1'b0, rem_shift} - {2'b00, opnd_q};
    q_bit     = ~rem_diff[XLEN+1];
    rem_step  = q_bit ? rem_diff[XLEN:0] : rem_shift;
    quo_step  = {quo_q[XLEN-2:0], q_bit};

    case (op_q)
      2'b00:   res_step = prod_step[XLEN-1:0];
      2'b01:   res_step = prod_step[2*XLEN-1:XLEN];
      2'b10:   res_step = quo_step;
      default: res_step = rem_step[XLEN-1:0];
    endcase
  end

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (i_start) begin
          state_nxt = div_zero ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (last_iter) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (i_start) begin
          state_nxt = div_zero ? S_DONE : S_RUN;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    o_busy = (state == S_RUN);
    o_done = (state == S_DONE);
  end

  assign o_result = result_q;

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      op_q     <= 2'b00;
      opnd_q   <= '0;
      cnt_q    <= '0;
      prod_q   <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      result_q <= '0;
    end else if (accept) begin
      op_q   <= i_op;
      opnd_q <= i_op[1] ? i_b : i_a;
      cnt_q  <= '0;
      prod_q <= {{XLEN{1'b0}}, i_b};
      rem_q  <= '0;
      quo_q  <= i_a;
      // Divide-by-zero skips RUN entirely: RISC-V defines the quotient as
      // all ones and the remainder as the dividend.
      if (div_zero) begin
        result_q <= i_op[0] ? i_a : {XLEN{1'b1}};
      end
    end else if (state == S_RUN) begin
      prod_q <= prod_step;
      rem_q  <= rem_step;
      quo_q  <= quo_step;
      cnt_q  <= cnt_q + CNT_W'(1);
      // Final iteration is folded straight into the result register so it
      // is valid in the same cycle o_done rises.
      if (last_iter) begin
        result_q <= res_step;
      end
    end
  end

endmodule
